// File: rtl/aclint_if.sv
// aclint_if: request/response bundle of the RV1 peripheral bus as seen by the ACLINT.
//   req_valid/addr/we/wdata/wstrb : byte-strobed request, accepted in the cycle it is valid
//   req_ready                      : high once the block is out of reset
//   rsp_valid/rdata/err            : registered response, one cycle after each request
// Modports: master drives requests (core/bench), slave answers them (aclint).
interface aclint_if;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_we;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/aclint.sv
// aclint: core-local interruptor with a shared 64-bit MTIME (programmable prescaler
// and halt), per-hart MTIMECMP/MSIP and an optional supervisor software-interrupt device.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           aclint_if.slave request/response port (offsets from base 0x0200_0000)
//   mti_o         per-hart machine timer interrupt (registered MTIME >= MTIMECMP)
//   msi_o         per-hart machine software interrupt (MSIP bit 0)
//   ssi_o         per-hart supervisor software interrupt, one-cycle pulse
//   time_o        current MTIME
//
// Build option: define ACLINT_SSWI_EN to decode the SETSSIP region at 0xC000 and drive
// ssi_o; without it 0xC000 and above answers with rsp_err and ssi_o stays 0.
//
// Map: MSIP[h] 0x0000+4h, MTIMECMP[h] 0x4000+8h, CTRL 0xBFF0 (DIV[15:0], HALT[31]),
//      MTIME 0xBFF8, SETSSIP[h] 0xC000+4h.
module aclint #(
    parameter int unsigned NUM_HARTS      = 1,
    parameter int unsigned PRESCALE_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    aclint_if.slave              bus,
    output logic [NUM_HARTS-1:0] mti_o,
    output logic [NUM_HARTS-1:0] msi_o,
    output logic [NUM_HARTS-1:0] ssi_o,
    output logic [63:0]          time_o
);

    localparam logic [15:0] DIV_RESET = 16'(PRESCALE_RESET - 1);

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    logic                 ready_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [63:0]          rsp_rdata_q;
    logic [63:0]          mtime_q;
    logic [63:0]          mtimecmp_q [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip_q;
    logic [NUM_HARTS-1:0] mti_q;
    logic [15:0]          div_q;
    logic [15:0]          pre_cnt_q;
    logic                 halt_q;

    logic        accept;
    logic        wr;
    logic [11:0] idx32;
    logic [10:0] idx64;
    logic        lane_hi;
    logic        lane_strb;
    logic        lane_bit0;
    logic        hit_msip;
    logic        hit_cmp;
    logic        hit_ctrl;
    logic        hit_mtime;
    logic        dec_err;
    logic [63:0] rd_val;
    logic        tick;
    logic        unused_addr_lsb;
`ifdef ACLINT_SSWI_EN
    logic        hit_ssip;
`endif

    assign accept          = bus.req_valid & ready_q;
    assign wr              = accept & bus.req_we;
    assign idx32           = bus.req_addr[13:2];
    assign idx64           = bus.req_addr[13:3];
    assign unused_addr_lsb = ^bus.req_addr[1:0];

    // 32-bit registers sit in the lane half picked by addr[2]; only their bit 0 is live.
    assign lane_hi   = bus.req_addr[2];
    assign lane_strb = lane_hi ? bus.req_wstrb[4]  : bus.req_wstrb[0];
    assign lane_bit0 = lane_hi ? bus.req_wdata[32] : bus.req_wdata[0];

    assign tick = ~halt_q & (pre_cnt_q == div_q);

    always_comb begin
        hit_msip  = 1'b0;
        hit_cmp   = 1'b0;
        hit_ctrl  = 1'b0;
        hit_mtime = 1'b0;
        dec_err   = 1'b0;
`ifdef ACLINT_SSWI_EN
        hit_ssip  = 1'b0;
`endif
        case (bus.req_addr[15:14])
            2'b00: begin
                if (32'(idx32) < NUM_HARTS) hit_msip = 1'b1;
                else                        dec_err  = 1'b1;
            end
            2'b01: begin
                if (32'(idx64) < NUM_HARTS) hit_cmp = 1'b1;
                else                        dec_err = 1'b1;
            end
            2'b10: begin
                // CTRL is a 32-bit register in the low half of 0xBFF0; 0xBFF4 is a hole.
                if (bus.req_addr[15:2] == 14'h2FFC)      hit_ctrl  = 1'b1;
                else if (bus.req_addr[15:3] == 13'h17FF) hit_mtime = 1'b1;
                else                                     dec_err   = 1'b1;
            end
            default: begin
`ifdef ACLINT_SSWI_EN
                if (32'(idx32) < NUM_HARTS) hit_ssip = 1'b1;
                else                        dec_err  = 1'b1;
`else
                dec_err = 1'b1;
`endif
            end
        endcase
    end

    // Read value of the addressed register; zero for SETSSIP and on decode error.
    always_comb begin
        rd_val = '0;
        if (hit_msip) begin
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                if (32'(idx32) == h)
                    rd_val = lane_hi ? {31'b0, msip_q[h], 32'b0} : {63'b0, msip_q[h]};
            end
        end else if (hit_cmp) begin
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                if (32'(idx64) == h) rd_val = mtimecmp_q[h];
            end
        end else if (hit_ctrl) begin
            rd_val = {32'b0, halt_q, 15'b0, div_q};
        end else if (hit_mtime) begin
            rd_val = mtime_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mtime_q     <= '0;
            div_q       <= DIV_RESET;
            halt_q      <= 1'b0;
            pre_cnt_q   <= '0;
            msip_q      <= '0;
            mti_q       <= '0;
            for (int unsigned h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
        end else begin
            ready_q     <= 1'b1;
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & dec_err;
            rsp_rdata_q <= (accept & ~bus.req_we) ? rd_val : '0;

            // A software write to MTIME overrides (and swallows) a coincident tick.
            if (wr & hit_mtime)
                mtime_q <= merge_bytes(mtime_q, bus.req_wdata, bus.req_wstrb);
            else if (tick)
                mtime_q <= mtime_q + 64'd1;

            if (wr & (hit_mtime | hit_ctrl)) pre_cnt_q <= '0;
            else if (tick)                   pre_cnt_q <= '0;
            else if (!halt_q)                pre_cnt_q <= pre_cnt_q + 16'd1;

            if (wr & hit_ctrl) begin
                if (bus.req_wstrb[0]) div_q[7:0]  <= bus.req_wdata[7:0];
                if (bus.req_wstrb[1]) div_q[15:8] <= bus.req_wdata[15:8];
                if (bus.req_wstrb[3]) halt_q      <= bus.req_wdata[31];
            end

            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                if (wr & hit_msip & lane_strb && (32'(idx32) == h))
                    msip_q[h] <= lane_bit0;
                if (wr & hit_cmp && (32'(idx64) == h))
                    mtimecmp_q[h] <= merge_bytes(mtimecmp_q[h], bus.req_wdata, bus.req_wstrb);
                // Compare uses pre-update values, so a write shows on mti_o one edge later.
                mti_q[h] <= (mtime_q >= mtimecmp_q[h]);
            end
        end
    end

`ifdef ACLINT_SSWI_EN
    logic [NUM_HARTS-1:0] ssi_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ssi_q <= '0;
        end else begin
            for (int unsigned h = 0; h < NUM_HARTS; h++)
                ssi_q[h] <= wr & hit_ssip & lane_strb & lane_bit0 & (32'(idx32) == h);
        end
    end

    assign ssi_o = ssi_q;
`else
    assign ssi_o = '0;
`endif

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign mti_o         = mti_q;
    assign msi_o         = msip_q;
    assign time_o        = mtime_q;

endmodule

// File: doc/aclint.md
# aclint

Parametrised Advanced Core-Local Interruptor for the RV1 peripheral bus, successor to the single-mode CLINT. Provides a shared 64-bit MTIME with a runtime-programmable prescaler and halt, per-hart MTIMECMP and MSIP, and an optional supervisor software-interrupt (SSWI) device. Uses a byte-strobed request port with a registered one-cycle response. Sits at base 0x0200_0000; drives the per-hart MTIP/MSIP/SSIP inputs of each core and the `time` CSR shadow.

## Interface
- NUM_HARTS, 1, number of harts (1..64)
- PRESCALE_RESET, 1, reset divisor; MTIME ticks every PRESCALE_RESET cycles (1..65536)
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_addr  in  16  byte offset from base
- req_we  in  1  1 = write
- req_wdata  in  64  write data, little-endian lanes
- req_wstrb  in  8  byte-lane enables for the 8-byte word at req_addr[15:3]
- req_ready  out  1  constant 1 once out of reset; 0 during reset
- rsp_valid  out  1  response strobe
- rsp_rdata  out  64  read data, in the lanes selected by the request address
- rsp_err  out  1  unmapped address or hart index >= NUM_HARTS
- mti_o  out  NUM_HARTS  machine timer interrupt, registered
- msi_o  out  NUM_HARTS  machine software interrupt level
- ssi_o  out  NUM_HARTS  supervisor software interrupt, one-cycle pulse
- time_o  out  64  current MTIME

## Operation
- Address map:
  - MSIP[h] at 0x0000+4h (bit 0 only).
  - MTIMECMP[h] at 0x4000+8h.
  - CTRL at 0xBFF0: [15:0] DIV = divisor-1; [31] HALT; other bits read 0.
  - MTIME at 0xBFF8.
  - SETSSIP[h] at 0xC000+4h.
- 32-bit registers occupy lanes 0-3 when addr[2]=0 and lanes 4-7 when addr[2]=1. Only strobed bytes are written.
- Prescaler: a 16-bit counter increments each cycle unless HALT is set. When it equals DIV, it clears and MTIME increments.
- MTIME wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
- A write to MTIME or CTRL clears the prescaler counter.
- A write to MTIME in the same cycle as a tick: the write wins; the tick is lost.
- mti_o[h] is registered from (MTIME >= MTIMECMP[h]), unsigned 64-bit compare, using register values before the current cycle's update.
- msi_o[h] = MSIP[h] bit 0.
- SETSSIP: a write with bit 0 = 1 pulses ssi_o[h] for exactly one cycle. A write with bit 0 = 0 is ignored. Reads return 0.
- Writes to reserved bits, out-of-range harts or unmapped offsets have no register effect.
- Reset values:
  - MTIME = 0; MTIMECMP = all-ones; MSIP = 0.
  - DIV = PRESCALE_RESET-1; HALT = 0; prescaler counter = 0.
  - All outputs 0 except req_ready = 0 and time_o = 0.

## Timing
- Every request with req_valid=1 is accepted in that cycle.
- rsp_valid asserts exactly one cycle after each accepted request, whether read or write.
- rsp_rdata returns the register value sampled at acceptance, before that cycle's tick or write. It is 0 for writes and on error.
- Back-to-back requests produce back-to-back responses.
- Register writes take effect at the accepting edge. The effect appears on mti_o one cycle after that, so MTIMECMP write to mti_o change is 2 edges.
- Asynchronous reset at any time aborts any pending response: rsp_valid drops immediately, and ssi_o pulses are lost.

## Configuration
- ACLINT_SSWI_EN defined: the SETSSIP region at 0xC000 is decoded and ssi_o is driven as above.
- ACLINT_SSWI_EN undefined: 0xC000 and above is unmapped (rsp_err=1), and ssi_o is tied to 0.

## Test plan
- Reset with PRESCALE_RESET=4, release, wait 40 cycles -> MTIME reads 10 (±1); mti_o=0; MTIMECMP[0] reads 0xFFFF_FFFF_FFFF_FFFF.
- Write CTRL=0x8000_0000 (HALT) -> MTIME frozen over 100 cycles. Write CTRL=0 -> MTIME increments every cycle.
- Write MTIME=0xFFFF_FFFF_FFFF_FFFE with DIV=0 -> reads 0 then 1 on successive cycles (wrap). MTIMECMP[0]=5 -> mti_o[0] rises 2 edges after MTIME reaches 5.
- NUM_HARTS=2: write MSIP[1]=1 via lanes 4-7 (addr 0x0004, wstrb=0xF0) -> msi_o=2'b10. Read 0x0008 -> rsp_err=1, rdata=0.
- Write SETSSIP[0]=1 with ACLINT_SSWI_EN -> ssi_o[0] high exactly one cycle, and a read returns 0. Without the macro -> rsp_err=1 and ssi_o stays 0.
- Write MTIMECMP[0] low word only (wstrb=0x0F, data 0x10) -> reads 0xFFFF_FFFF_0000_0010. Assert reset_n low mid-response -> rsp_valid=0 immediately.
